// File: rtl/inscache_pkg.sv
// Shared constants and FSM encoding for the instruction cache.
package inscache_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = 4;
    localparam int LINE_BITS      = LINE_BYTES * 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/inscache_array.sv
// Tag, valid and data storage for the instruction cache.
// Two combinational line read ports, one word write port and one tag/valid strobe.
module inscache_array
    import inscache_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 32 - OFFSET_W - INDEX_W
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic [INDEX_W-1:0]   idx_a_i,
    output logic                 valid_a_o,
    output logic [TAG_W-1:0]     tag_a_o,
    output logic [LINE_BITS-1:0] line_a_o,
    input  logic [INDEX_W-1:0]   idx_b_i,
    output logic                 valid_b_o,
    output logic [TAG_W-1:0]     tag_b_o,
    output logic [LINE_BITS-1:0] line_b_o,
    input  logic                 word_we_i,
    input  logic [INDEX_W-1:0]   word_idx_i,
    input  logic [1:0]           word_sel_i,
    input  logic [31:0]          word_data_i,
    input  logic                 tag_we_i,
    input  logic [INDEX_W-1:0]   tag_idx_i,
    input  logic [TAG_W-1:0]     tag_data_i
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[tag_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_we_i) begin
            tag_q[tag_idx_i] <= tag_data_i;
        end
    end

    assign valid_a_o = valid_q[idx_a_i];
    assign valid_b_o = valid_q[idx_b_i];
    assign tag_a_o   = tag_q[idx_a_i];
    assign tag_b_o   = tag_q[idx_b_i];

    // One storage array per word column so each fill handshake writes a single word.
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
        logic [31:0] word_q [LINES];

        always_ff @(posedge clk_i) begin
            if (word_we_i && (word_sel_i == 2'(gi))) begin
                word_q[word_idx_i] <= word_data_i;
            end
        end

        assign line_a_o[gi*32 +: 32] = word_q[idx_a_i];
        assign line_b_o[gi*32 +: 32] = word_q[idx_b_i];
    end

endmodule

// File: rtl/inscache.sv
// Direct-mapped instruction cache: 32-bit window at any halfword PC, zero-latency hits,
// line fills of four words from the memory controller.
module inscache
    import inscache_pkg::*;
#(
    parameter int INDEX_W = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] out_PC,
    input  logic        ask_for,
    output logic        give_you,
    output logic [31:0] g_ins,
    output logic        mem_ask,
    output logic [31:0] mem_addr,
    input  logic        mem_give,
    input  logic [31:0] mem_data
);

    localparam int TAG_W  = 32 - OFFSET_W - INDEX_W;
    localparam int LINE_W = 32 - OFFSET_W;

    state_t            state_q, state_d;
    logic [1:0]        w_q, w_d;
    logic [LINE_W-1:0] base_q, base_d;

    logic [LINE_W-1:0]    line_num_a, line_num_b;
    logic [2:0]           k, k_next;
    logic                 valid_a, valid_b;
    logic [TAG_W-1:0]     tag_a, tag_b;
    logic [LINE_BITS-1:0] line_a, line_b;
    logic [15:0]          lo, hi;
    logic                 hit_a, hit_b, need2, hit;
    logic                 word_we, tag_we;
    logic                 unused_ok;

    // PC+2 only leaves the current line when k==7.
    assign k          = out_PC[3:1];
    assign k_next     = k + 3'd1;
    assign line_num_a = out_PC[31:4];
    assign line_num_b = line_num_a + LINE_W'(k == 3'd7);

    inscache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk_i       (clk_in),
        .srst_i      (rst_in),
        .idx_a_i     (line_num_a[INDEX_W-1:0]),
        .valid_a_o   (valid_a),
        .tag_a_o     (tag_a),
        .line_a_o    (line_a),
        .idx_b_i     (line_num_b[INDEX_W-1:0]),
        .valid_b_o   (valid_b),
        .tag_b_o     (tag_b),
        .line_b_o    (line_b),
        .word_we_i   (word_we),
        .word_idx_i  (base_q[INDEX_W-1:0]),
        .word_sel_i  (w_q),
        .word_data_i (mem_data),
        .tag_we_i    (tag_we),
        .tag_idx_i   (base_q[INDEX_W-1:0]),
        .tag_data_i  (base_q[LINE_W-1:INDEX_W])
    );

    assign lo    = line_a[{k, 4'b0000} +: 16];
    assign hi    = (k == 3'd7) ? line_b[15:0] : line_a[{k_next, 4'b0000} +: 16];
    assign hit_a = valid_a && (tag_a == line_num_a[LINE_W-1:INDEX_W]);
    assign hit_b = valid_b && (tag_b == line_num_b[LINE_W-1:INDEX_W]);
    // A compressed instruction in the last halfword never needs the next line.
    assign need2 = (k == 3'd7) && (lo[1:0] == 2'b11);
    assign hit   = hit_a && (!need2 || hit_b);

    assign g_ins    = {hi, lo};
    assign give_you = !rst_in && rdy_in && ask_for && hit && (state_q == ST_IDLE);
    assign mem_ask  = (state_q == ST_FILL);
    assign mem_addr = mem_ask ? {base_q, w_q, 2'b00} : 32'd0;

    assign unused_ok = ^{out_PC[0], line_b[LINE_BITS-1:16]};

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        base_d  = base_q;
        word_we = 1'b0;
        tag_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rdy_in && ask_for && !hit) begin
                    state_d = ST_FILL;
                    w_d     = 2'd0;
                    base_d  = hit_a ? line_num_b : line_num_a;
                end
            end
            ST_FILL: begin
                // The latched line always completes, whatever the PC does meanwhile.
                if (rdy_in && mem_give) begin
                    word_we = 1'b1;
                    if (w_q == 2'd3) begin
                        tag_we  = 1'b1;
                        state_d = ST_IDLE;
                        w_d     = 2'd0;
                    end else begin
                        w_d = w_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            w_q     <= 2'd0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_inscache.sv
// Self-checking bench for inscache: table of hit vectors plus fill sequences,
// with a memory responder checking request addresses against a scoreboard queue.
module tb_inscache;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, ask_for, mem_give;
    logic [31:0] out_PC, mem_data;
    logic        give_you, mem_ask;
    logic [31:0] g_ins, mem_addr;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] sb[$];
    bit          gaps_en = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic        ask;
        logic        rdy;
        logic        exp_give;
        logic [31:0] exp_ins;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs[10];

    inscache #(.INDEX_W(5)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .out_PC   (out_PC),
        .ask_for  (ask_for),
        .give_you (give_you),
        .g_ins    (g_ins),
        .mem_ask  (mem_ask),
        .mem_addr (mem_addr),
        .mem_give (mem_give),
        .mem_data (mem_data)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_000C: return 32'h4501_1234;
            32'h0000_004C: return 32'h0093_5678;
            32'h0000_007C: return 32'h00B3_9ABC;
            default:       return {a[15:0] ^ 16'hBEE4, a[15:0] ^ 16'h1350};
        endcase
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] exp_ins(input logic [31:0] pc);
        return {hw_at(pc + 32'd2), hw_at(pc)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) sb.push_back(base + 32'(4 * i));
    endtask

    task automatic apply(input logic [31:0] pc, input logic ask);
        @(negedge clk_in);
        out_PC  = pc;
        ask_for = ask;
        #1;
    endtask

    task automatic wait_hit(input string name, input logic [31:0] exp, input logic [31:0] mask,
                            output int cycles);
        cycles = 0;
        while (!give_you && cycles < 60) begin
            @(negedge clk_in);
            #1;
            cycles++;
        end
        if (give_you !== 1'b1) begin
            check({name, " hit timeout"}, 32'(give_you), 32'd1);
        end else begin
            check({name, " g_ins"}, g_ins & mask, exp & mask);
            check({name, " pending fills"}, 32'(sb.size()), 32'd0);
        end
        $display("[TB] %s pc=%h hit after %0d cycles g_ins=%h", name, out_PC, cycles, g_ins);
    endtask

    // Memory controller model: answers at most one word per cycle while asked.
    initial begin
        mem_give = 1'b0;
        mem_data = 32'd0;
        forever begin
            @(negedge clk_in);
            #2;
            if (mem_ask === 1'b1 && rdy_in && !rst_in && !(gaps_en && $urandom_range(0, 2) == 0)) begin
                if (sb.size() == 0) begin
                    check("unexpected mem_ask", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    check("mem_addr", mem_addr, sb.pop_front());
                end
                mem_give = 1'b1;
                mem_data = mem_word(mem_addr);
            end
            @(posedge clk_in);
            #1;
            mem_give = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_in  = 1'b1;
        rdy_in  = 1'b1;
        ask_for = 1'b1;
        out_PC  = 32'd0;

        // Reset state.
        repeat (2) @(negedge clk_in);
        #1;
        check("reset give_you", 32'(give_you), 32'd0);
        check("reset mem_ask", 32'(mem_ask), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);

        // Cold miss at PC 0: four words, give_you the cycle after the 4th give.
        @(negedge clk_in);
        rst_in = 1'b0;
        push_fill(32'h0);
        #1;
        check("cold give_you", 32'(give_you), 32'd0);
        wait_hit("cold pc0", 32'h0000_0013, 32'hFFFF_FFFF, cyc);
        check("cold latency", 32'(cyc), 32'd5);

        // Table of same-cycle hits on the warm line 0x00-0x0F.
        vecs[0] = '{32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF};
        vecs[1] = '{32'h2, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF};
        vecs[2] = '{32'h4, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF};
        vecs[3] = '{32'h6, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF};
        vecs[4] = '{32'h8, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF};
        vecs[5] = '{32'hA, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF};
        vecs[6] = '{32'hC, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF};
        vecs[7] = '{32'hE, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_FFFF};
        vecs[8] = '{32'h6, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF};
        vecs[9] = '{32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF};
        foreach (vecs[i]) vecs[i].exp_ins = exp_ins(vecs[i].pc);

        foreach (vecs[i]) begin
            @(negedge clk_in);
            out_PC  = vecs[i].pc;
            ask_for = vecs[i].ask;
            rdy_in  = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d give_you", i), 32'(give_you), 32'(vecs[i].exp_give));
            check($sformatf("vec%0d mem_ask", i), 32'(mem_ask), 32'd0);
            check($sformatf("vec%0d g_ins", i), g_ins & vecs[i].mask, vecs[i].exp_ins & vecs[i].mask);
            $display("[TB] vec%0d pc=%h ask=%b rdy=%b give=%b g_ins=%h",
                     i, out_PC, ask_for, rdy_in, give_you, g_ins);
        end
        rdy_in = 1'b1;

        // k==7 with a 32-bit instruction: only the next line is fetched.
        apply(32'h40, 1'b1);
        push_fill(32'h40);
        wait_hit("line 0x40", exp_ins(32'h40), 32'hFFFF_FFFF, cyc);
        apply(32'h4E, 1'b1);
        check("split miss give_you", 32'(give_you), 32'd0);
        push_fill(32'h50);
        wait_hit("split pc 0x4E", exp_ins(32'h4E), 32'hFFFF_FFFF, cyc);

        // k==7 with both lines cold: two sequential fills, with gaps in the responses.
        gaps_en = 1'b1;
        apply(32'h7E, 1'b1);
        push_fill(32'h70);
        push_fill(32'h80);
        wait_hit("double fill 0x7E", exp_ins(32'h7E), 32'hFFFF_FFFF, cyc);
        gaps_en = 1'b0;

        // Conflict on index 0: 0x200 evicts line 0, which then refills.
        apply(32'h200, 1'b1);
        push_fill(32'h200);
        wait_hit("conflict 0x200", exp_ins(32'h200), 32'hFFFF_FFFF, cyc);
        apply(32'h0, 1'b1);
        check("evicted pc0 give_you", 32'(give_you), 32'd0);
        push_fill(32'h0);
        wait_hit("refill pc0", 32'h0000_0013, 32'hFFFF_FFFF, cyc);

        // PC moves mid-fill: the 0x100 fill completes before 0x300 is fetched.
        apply(32'h100, 1'b1);
        push_fill(32'h100);
        push_fill(32'h300);
        apply(32'h300, 1'b1);
        wait_hit("redirect 0x300", exp_ins(32'h300), 32'hFFFF_FFFF, cyc);

        // rdy_in low mid-fill freezes the word counter; the fill resumes at the same word.
        apply(32'h640, 1'b1);
        push_fill(32'h640);
        for (int i = 0; i < 20 && sb.size() > 2; i++) @(negedge clk_in);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d give_you", i), 32'(give_you), 32'd0);
            check($sformatf("stall%0d mem_addr", i), mem_addr, 32'h648);
            @(negedge clk_in);
        end
        rdy_in = 1'b1;
        #1;
        wait_hit("resume 0x640", exp_ins(32'h640), 32'hFFFF_FFFF, cyc);

        // Reset mid-fill aborts the fill and invalidates every line.
        apply(32'h900, 1'b1);
        push_fill(32'h900);
        for (int i = 0; i < 20 && sb.size() > 2; i++) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        #1;
        check("abort mem_ask", 32'(mem_ask), 32'd0);
        check("abort mem_addr", mem_addr, 32'd0);
        sb.delete();
        @(negedge clk_in);
        rst_in = 1'b0;
        out_PC = 32'h0;
        ask_for = 1'b1;
        push_fill(32'h0);
        #1;
        check("post-reset pc0 give_you", 32'(give_you), 32'd0);
        wait_hit("post-reset pc0", 32'h0000_0013, 32'hFFFF_FFFF, cyc);

        apply(32'h0, 1'b0);
        repeat (3) @(negedge clk_in);
        check("final scoreboard", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
